run_sequencer: RTL and testbench

Test-harness initiator for the processor's Reset/Start/Ack program handshake. It drives the processor's reset and start inputs, then waits for the done flag. It runs `NUM_PROGS` programs back to back and measures each one's cycle count, with a timeout guard. Per-program results are reported to the bench or to a scoreboard. It sits beside the processor top level, on the opposite side of its `Reset`/`Start`/`Ack` pins.

---
 rtl/run_sequencer.sv | 150 +++++++++++++++
 tb/tb_run_sequencer.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/run_sequencer.sv
// Test-harness initiator for a processor's Reset/Start/Ack program handshake.
// It runs NUM_PROGS programs back to back and reports each program's cycle count, with a timeout guard.
`timescale 1ns/1ps

module run_sequencer #(
   parameter int NUM_PROGS = 3,
   parameter int CNT_W     = 16,
   parameter int TIMEOUT   = 1000,
   parameter int RST_CYC   = 2,
   localparam int PW       = (NUM_PROGS > 1) ? $clog2(NUM_PROGS) : 1
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic             Go,
   input  logic             DutAck,
   output logic             DutReset,
   output logic             DutStart,
   output logic [PW-1:0]    ProgIdx,
   output logic [CNT_W-1:0] CycleCt,
   output logic             ResultValid,
   output logic             TimedOut,
   output logic             Busy,
   output logic             Done
);

   localparam int RW = (RST_CYC > 1) ? $clog2(RST_CYC) : 1;
   localparam logic [RW-1:0]    LAST_RST = RW'(RST_CYC - 1);
   localparam logic [PW-1:0]    LAST_IDX = PW'(NUM_PROGS - 1);
   localparam logic [CNT_W-1:0] TMO_CT   = CNT_W'(TIMEOUT);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_DRST   = 3'd1,
      S_START  = 3'd2,
      S_RUN    = 3'd3,
      S_REPORT = 3'd4,
      S_DONE   = 3'd5
   } state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [RW-1:0]    r_rst_cnt;
   logic [RW-1:0]    w_rst_cnt_nxt;
   logic [PW-1:0]    r_prog_idx;
   logic [PW-1:0]    w_prog_idx_nxt;
   logic [CNT_W-1:0] r_cycle_ct;
   logic [CNT_W-1:0] w_cycle_ct_run;
   logic [CNT_W-1:0] w_cycle_ct_nxt;
   logic             r_timed_out;
   logic             w_timed_out_nxt;
   logic             r_dut_reset;
   logic             r_dut_start;
   logic             r_result_valid;
   logic             r_busy;
   logic             r_done;

   // Next-state and next-output logic; every output register is loaded from the state it is entering.
   always_comb begin
      w_state_nxt     = r_state;
      w_rst_cnt_nxt   = r_rst_cnt;
      w_prog_idx_nxt  = r_prog_idx;
      w_cycle_ct_run  = r_cycle_ct;
      w_timed_out_nxt = r_timed_out;
      case (r_state)
         S_IDLE, S_DONE: begin
            if (Go) begin
               w_state_nxt     = S_DRST;
               w_rst_cnt_nxt   = {RW{1'b0}};
               w_prog_idx_nxt  = {PW{1'b0}};
               w_cycle_ct_run  = {CNT_W{1'b0}};
               w_timed_out_nxt = 1'b0;
            end else begin
               w_state_nxt = r_state;
            end
         end
         S_DRST: begin
            if (r_rst_cnt == LAST_RST) begin
               w_state_nxt = S_START;
            end else begin
               w_rst_cnt_nxt = r_rst_cnt + {{(RW-1){1'b0}}, 1'b1};
            end
         end
         S_START: begin
            w_state_nxt = S_RUN;
         end
         // Ack takes priority over the timeout when both land in the same cycle.
         S_RUN: begin
            if (DutAck) begin
               w_state_nxt     = S_REPORT;
               w_timed_out_nxt = 1'b0;
            end else if (r_cycle_ct == TMO_CT) begin
               w_state_nxt     = S_REPORT;
               w_timed_out_nxt = 1'b1;
            end else begin
               w_cycle_ct_run = r_cycle_ct + {{(CNT_W-1){1'b0}}, 1'b1};
            end
         end
         S_REPORT: begin
            if (r_timed_out || (r_prog_idx == LAST_IDX)) begin
               w_state_nxt = S_DONE;
            end else begin
               w_state_nxt    = S_START;
               w_prog_idx_nxt = r_prog_idx + {{(PW-1){1'b0}}, 1'b1};
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
      // The count reads zero for the whole START cycle; a stale Ack there cannot affect it.
      w_cycle_ct_nxt = (w_state_nxt == S_START) ? {CNT_W{1'b0}} : w_cycle_ct_run;
   end

   // State and output registers; Reset clears everything at once.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         r_state        <= S_IDLE;
         r_rst_cnt      <= {RW{1'b0}};
         r_prog_idx     <= {PW{1'b0}};
         r_cycle_ct     <= {CNT_W{1'b0}};
         r_timed_out    <= 1'b0;
         r_dut_reset    <= 1'b0;
         r_dut_start    <= 1'b0;
         r_result_valid <= 1'b0;
         r_busy         <= 1'b0;
         r_done         <= 1'b0;
      end else begin
         r_state        <= w_state_nxt;
         r_rst_cnt      <= w_rst_cnt_nxt;
         r_prog_idx     <= w_prog_idx_nxt;
         r_cycle_ct     <= w_cycle_ct_nxt;
         r_timed_out    <= w_timed_out_nxt;
         r_dut_reset    <= (w_state_nxt == S_DRST);
         r_dut_start    <= (w_state_nxt == S_START);
         r_result_valid <= (w_state_nxt == S_REPORT);
         r_busy         <= (w_state_nxt != S_IDLE) && (w_state_nxt != S_DONE);
         r_done         <= (w_state_nxt == S_DONE);
      end
   end

   assign DutReset    = r_dut_reset;
   assign DutStart    = r_dut_start;
   assign ProgIdx     = r_prog_idx;
   assign CycleCt     = r_cycle_ct;
   assign ResultValid = r_result_valid;
   assign TimedOut    = r_timed_out;
   assign Busy        = r_busy;
   assign Done        = r_done;

endmodule

// File: tb/tb_run_sequencer.sv
// Directed bench for run_sequencer: NUM_PROGS=3, RST_CYC=2, TIMEOUT=20.
// It plays the processor side of the handshake with scripted Ack delays.
`timescale 1ns/1ps

module tb_run_sequencer;

   logic        Clk;
   logic        Reset;
   logic        Go;
   logic        DutAck;
   logic        DutReset;
   logic        DutStart;
   logic [1:0]  ProgIdx;
   logic [15:0] CycleCt;
   logic        ResultValid;
   logic        TimedOut;
   logic        Busy;
   logic        Done;

   int n_tests = 0;
   int n_fail  = 0;
   int n_start = 0;
   int n_drst  = 0;
   int n_valid = 0;
   int snap;
   int seen;
   int cnt;

   run_sequencer #(
      .NUM_PROGS(3),
      .CNT_W    (16),
      .TIMEOUT  (20),
      .RST_CYC  (2)
   ) dut (
      .Clk        (Clk),
      .Reset      (Reset),
      .Go         (Go),
      .DutAck     (DutAck),
      .DutReset   (DutReset),
      .DutStart   (DutStart),
      .ProgIdx    (ProgIdx),
      .CycleCt    (CycleCt),
      .ResultValid(ResultValid),
      .TimedOut   (TimedOut),
      .Busy       (Busy),
      .Done       (Done)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   // Cycle-level event counters, sampled on the rising edge that closes each cycle.
   always @(posedge Clk) begin
      if (DutStart === 1'b1) n_start <= n_start + 1;
      if (DutReset === 1'b1) n_drst <= n_drst + 1;
      if (ResultValid === 1'b1) n_valid <= n_valid + 1;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: time limit reached, %0d tests run", n_tests);
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_zero(input string tag);
      chk(tag, 32'({DutReset, DutStart, ProgIdx, CycleCt, ResultValid, TimedOut, Busy, Done}), 32'd0);
   endtask

   // Waits (bounded) for the START cycle and checks the program index shown there.
   task automatic wait_start(input int idx);
      int found;
      found = 0;
      for (int k = 0; k < 60; k++) begin
         @(negedge Clk);
         if (DutStart === 1'b1) begin
            found = 1;
            break;
         end
      end
      chk("start_seen", 32'(found), 32'd1);
      chk("start_idx", 32'(ProgIdx), 32'(idx));
      chk("start_ct", 32'(CycleCt), 32'd0);
   endtask

   // One program: Ack is low for d RUN cycles, then high for one; results checked in REPORT.
   task automatic run_prog(input int idx, input int d);
      wait_start(idx);
      @(negedge Clk);
      Go = 1'b0;
      for (int j = 0; j < d; j++) begin
         DutAck = 1'b0;
         @(negedge Clk);
      end
      DutAck = 1'b1;
      @(negedge Clk);
      DutAck = 1'b0;
      chk("rep_valid", 32'(ResultValid), 32'd1);
      chk("rep_idx", 32'(ProgIdx), 32'(idx));
      chk("rep_ct", 32'(CycleCt), 32'(d));
      chk("rep_to", 32'(TimedOut), 32'd0);
   endtask

   initial begin
      Reset  = 1'b0;
      Go     = 1'b0;
      DutAck = 1'b0;

      // Asynchronous reset between edges, then idle with Go low
      #2 Reset = 1'b1;
      #1 chk_zero("reset_async");
      @(negedge Clk);
      @(negedge Clk);
      Reset = 1'b0;
      repeat (10) @(negedge Clk);
      chk_zero("idle_after_reset");

      // Normal run: Ack 5, 0, 12 cycles into RUN
      snap = n_drst;
      Go = 1'b1;
      @(negedge Clk);
      Go = 1'b0;
      chk("drst_high", 32'(DutReset), 32'd1);
      chk("drst_busy", 32'(Busy), 32'd1);
      cnt = n_start;
      seen = n_valid;
      run_prog(0, 5);
      run_prog(1, 0);
      run_prog(2, 12);
      @(negedge Clk);
      chk("norm_done", 32'(Done), 32'd1);
      chk("norm_busy", 32'(Busy), 32'd0);
      chk("norm_drst_cycles", 32'(n_drst - snap), 32'd2);
      chk("norm_starts", 32'(n_start - cnt), 32'd3);
      chk("norm_valids", 32'(n_valid - seen), 32'd3);

      // Stale Ack through DRST/START, then Ack 3 cycles in; program 1 acks exactly at the timeout boundary
      DutAck = 1'b1;
      Go = 1'b1;
      @(negedge Clk);
      Go = 1'b0;
      chk("rerun_done_clr", 32'(Done), 32'd0);
      run_prog(0, 3);
      run_prog(1, 20);
      run_prog(2, 1);
      @(negedge Clk);
      chk("stale_done", 32'(Done), 32'd1);

      // Timeout on program 1 aborts the sequence
      Go = 1'b1;
      @(negedge Clk);
      Go = 1'b0;
      run_prog(0, 2);
      wait_start(1);
      seen = 0;
      cnt = 0;
      for (int k = 0; k < 40; k++) begin
         @(negedge Clk);
         cnt++;
         if (ResultValid === 1'b1) begin
            seen = 1;
            break;
         end
      end
      chk("tmo_valid_seen", 32'(seen), 32'd1);
      chk("tmo_latency", 32'(cnt), 32'd22);
      chk("tmo_idx", 32'(ProgIdx), 32'd1);
      chk("tmo_ct", 32'(CycleCt), 32'd20);
      chk("tmo_flag", 32'(TimedOut), 32'd1);
      @(negedge Clk);
      chk("tmo_done", 32'(Done), 32'd1);
      chk("tmo_busy", 32'(Busy), 32'd0);
      snap = n_start;
      repeat (30) @(negedge Clk);
      chk("tmo_no_start", 32'(n_start - snap), 32'd0);
      chk("tmo_hold_idx", 32'(ProgIdx), 32'd1);
      chk("tmo_hold_to", 32'(TimedOut), 32'd1);

      // Restart from DONE clears indices; Go while Busy is ignored
      Go = 1'b1;
      @(negedge Clk);
      Go = 1'b0;
      chk("restart_drst", 32'(DutReset), 32'd1);
      chk("restart_idx", 32'(ProgIdx), 32'd0);
      chk("restart_to", 32'(TimedOut), 32'd0);
      chk("restart_ct", 32'(CycleCt), 32'd0);
      chk("restart_done", 32'(Done), 32'd0);
      run_prog(0, 4);
      snap = n_drst;
      Go = 1'b1;
      run_prog(1, 6);
      chk("busy_go_no_drst", 32'(n_drst - snap), 32'd0);

      // Reset in the middle of program 2's RUN
      wait_start(2);
      @(negedge Clk);
      @(negedge Clk);
      snap = n_valid;
      #2 Reset = 1'b1;
      #1 chk_zero("midrun_reset_async");
      @(negedge Clk);
      Reset = 1'b0;
      DutAck = 1'b1;
      repeat (8) @(negedge Clk);
      DutAck = 1'b0;
      chk_zero("midrun_idle");
      chk("midrun_no_valid", 32'(n_valid - snap), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
